conv_sequencer: RTL and testbench

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/conv_sequencer.sv | 151 +++++++++++++++
 tb/tb_conv_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
// Address/handshake sequencer for a 4x2 sliding-window convolution over a frame.
// Optional handshake stall counter: define CONV_SEQ_STALL_CNT_EN.
module conv_sequencer #(
  parameter int MUL_LAT = 2,
  parameter int DIM_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] img_w,
  input  logic [DIM_W-1:0] img_h,
  input  logic [31:0]      base_in,
  input  logic [31:0]      base_out,
  output logic             rd_req,
  input  logic             rd_ack,
  output logic [31:0]      rd_addr,
  output logic             wr_pos_pxl,
  output logic             we_pxl,
  output logic             we_mul,
  output logic             wr_req,
  input  logic             wr_ack,
  output logic [31:0]      wr_addr,
  output logic             wr_wom,
  output logic [DIM_W-1:0] i,
  output logic [DIM_W-1:0] j,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      stall_cnt
);

  typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, MUL, WAIT, STORE, NEXT, FIN} state_t;

  state_t           state, state_nx;
  logic [DIM_W-1:0] w_q, w_nx, h_q, h_nx, i_q, i_nx, j_q, j_nx;
  logic [31:0]      row_base, row_base_nx, out_ptr, out_ptr_nx;
  logic [3:0]       wcnt, wcnt_nx;
  logic             err_q, err_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      w_q      <= '0;
      h_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      row_base <= '0;
      out_ptr  <= '0;
      wcnt     <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      w_q      <= w_nx;
      h_q      <= h_nx;
      i_q      <= i_nx;
      j_q      <= j_nx;
      row_base <= row_base_nx;
      out_ptr  <= out_ptr_nx;
      wcnt     <= wcnt_nx;
      err_q    <= err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    w_nx        = w_q;
    h_nx        = h_q;
    i_nx        = i_q;
    j_nx        = j_q;
    row_base_nx = row_base;
    out_ptr_nx  = out_ptr;
    wcnt_nx     = wcnt;
    err_nx      = err_q;
    case (state)
      IDLE: if (start) begin
        if (img_w < DIM_W'(4) || img_h < DIM_W'(2)) begin
          err_nx   = 1'b1;
          state_nx = FIN;
        end else begin
          err_nx      = 1'b0;
          w_nx        = img_w;
          h_nx        = img_h;
          i_nx        = '0;
          j_nx        = '0;
          row_base_nx = base_in;
          out_ptr_nx  = base_out;
          state_nx    = FETCH0;
        end
      end
      FETCH0: if (rd_ack) state_nx = FETCH1;
      FETCH1: if (rd_ack) state_nx = MUL;
      MUL: begin
        wcnt_nx  = 4'(MUL_LAT - 1);
        state_nx = (MUL_LAT == 1) ? STORE : WAIT;
      end
      // MUL plus (MUL_LAT-1) WAIT cycles places wr_req MUL_LAT cycles after we_mul
      WAIT: begin
        wcnt_nx = wcnt - 4'd1;
        if (wcnt <= 4'd1) state_nx = STORE;
      end
      STORE: if (wr_ack) begin
        out_ptr_nx = out_ptr + 32'd1;
        state_nx   = NEXT;
      end
      NEXT: begin
        state_nx = FETCH0;
        if (j_q < w_q - DIM_W'(4)) begin
          j_nx = j_q + DIM_W'(1);
        end else begin
          j_nx        = '0;
          row_base_nx = row_base + 32'(w_q);
          if (i_q < h_q - DIM_W'(2)) i_nx = i_q + DIM_W'(1);
          else                       state_nx = FIN;
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign rd_req     = (state == FETCH0) || (state == FETCH1);
  assign rd_addr    = (state == FETCH0) ? row_base + 32'(j_q) :
                      (state == FETCH1) ? row_base + 32'(w_q) + 32'(j_q) : 32'd0;
  assign we_pxl     = rd_req && rd_ack;
  assign wr_pos_pxl = (state == FETCH1) && rd_ack;
  assign we_mul     = (state == MUL);
  assign wr_req     = (state == STORE);
  assign wr_wom     = wr_req;
  assign wr_addr    = wr_req ? out_ptr : 32'd0;
  assign i          = i_q;
  assign j          = j_q;
  assign busy       = (state != IDLE) && (state != FIN);
  assign done       = (state == FIN);
  assign err        = err_q;

`ifdef CONV_SEQ_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else if (state == IDLE && start)
      stall_q <= '0;
    else if (((rd_req && !rd_ack) || (wr_req && !wr_ack)) && stall_q != 32'hFFFF_FFFF)
      stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed self-checking bench for conv_sequencer (MUL_LAT=4 build).
module tb_conv_sequencer;
  localparam int MUL_LAT = 4;
`ifdef CONV_SEQ_STALL_CNT_EN
  localparam int EXP_STALL = 30;
`else
  localparam int EXP_STALL = 0;
`endif

  logic clk = 1'b0;
  logic rst, start, rd_ack, wr_ack;
  logic [15:0] img_w, img_h;
  logic [31:0] base_in, base_out;
  logic rd_req, wr_pos_pxl, we_pxl, we_mul, wr_req, wr_wom, busy, done, err;
  logic [31:0] rd_addr, wr_addr, stall_cnt;
  logic [15:0] i, j;

  conv_sequencer #(.MUL_LAT(MUL_LAT), .DIM_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .img_w(img_w), .img_h(img_h),
    .base_in(base_in), .base_out(base_out), .rd_req(rd_req), .rd_ack(rd_ack),
    .rd_addr(rd_addr), .wr_pos_pxl(wr_pos_pxl), .we_pxl(we_pxl), .we_mul(we_mul),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_wom(wr_wom),
    .i(i), .j(j), .busy(busy), .done(done), .err(err), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  logic [31:0] st_log [0:63];
  logic [31:0] rd_log [0:63];
  int n_st, n_rd, n_done, gap_err, stab_err, pxl_err, wom_err, st_err;
  bit timeout;
  int rd_dly = 0, wr_dly = 0;

  task automatic do_start(input logic [15:0] w, input logic [15:0] h,
                          input logic [31:0] bi, input logic [31:0] bo);
    @(negedge clk);
    img_w = w; img_h = h; base_in = bi; base_out = bo; start = 1'b1;
  endtask

  // Acts as memory responder; records fetch/store addresses and protocol anomalies.
  task automatic run_frame(input int inj_cyc, input bit stop_at_store);
    int cyc, rd_cnt, wr_cnt, mul_cyc;
    logic [31:0] held;
    bit fin;
    n_st = 0; n_rd = 0; n_done = 0; gap_err = 0; stab_err = 0; pxl_err = 0;
    wom_err = 0; timeout = 0;
    fin = 0; cyc = 0; rd_cnt = 0; wr_cnt = 0; mul_cyc = -100; held = '0;
    while (!fin) begin
      @(negedge clk);
      start = 1'b0; rd_ack = 1'b0; wr_ack = 1'b0; cyc++;
      if (cyc == inj_cyc) begin
        start = 1'b1; img_w = 16'd16; img_h = 16'd4; base_in = 32'h900; base_out = 32'h990;
      end
      if (wr_wom !== wr_req) wom_err++;
      if (rd_req === 1'b1) begin
        if (rd_cnt == 0) begin
          if (n_rd < 64) rd_log[n_rd] = rd_addr;
          n_rd++;
          held = rd_addr;
        end else if (rd_addr !== held) stab_err++;
        if (rd_cnt == rd_dly) begin rd_ack = 1'b1; rd_cnt = 0; end
        else rd_cnt++;
      end
      if (we_mul === 1'b1) mul_cyc = cyc;
      if (wr_req === 1'b1) begin
        if (wr_cnt == 0 && cyc - mul_cyc != MUL_LAT) gap_err++;
        if (stop_at_store) fin = 1;
        else if (wr_cnt == wr_dly) begin
          wr_ack = 1'b1; wr_cnt = 0;
          if (n_st < 64) st_log[n_st] = wr_addr;
          n_st++;
        end else wr_cnt++;
      end
      #1;
      if (rd_ack && (we_pxl !== 1'b1 || wr_pos_pxl !== 1'((n_rd - 1) % 2))) pxl_err++;
      if (!rd_ack && (we_pxl !== 1'b0 || wr_pos_pxl !== 1'b0)) pxl_err++;
      if (done === 1'b1) begin n_done++; fin = 1; end
      if (cyc > 4000) begin timeout = 1; fin = 1; end
    end
  endtask

  task automatic check_stores(input string nm, input int exp_n, input logic [31:0] bo);
    n_checks++;
    if (timeout || n_st !== exp_n) begin
      n_fail++; $display("FAIL %s store count: got %0d want %0d (timeout=%0d)", nm, n_st, exp_n, timeout);
    end
    st_err = 0;
    for (int k = 0; k < exp_n && k < 64; k++) if (st_log[k] !== bo + 32'(k)) st_err++;
    n_checks++;
    if (st_err != 0) begin
      n_fail++; $display("FAIL %s store addrs: %0d wrong, first got %h want %h", nm, st_err, st_log[0], bo);
    end
    n_checks++;
    if (n_done !== 1 || gap_err !== 0 || stab_err !== 0 || pxl_err !== 0 || wom_err !== 0) begin
      n_fail++;
      $display("FAIL %s protocol: done=%0d gap=%0d stab=%0d pxl=%0d wom=%0d want 1/0/0/0/0",
               nm, n_done, gap_err, stab_err, pxl_err, wom_err);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; rd_ack = 1'b0; wr_ack = 1'b0;
    img_w = '0; img_h = '0; base_in = '0; base_out = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rd_req, wr_req, wr_wom, we_pxl, we_mul, wr_pos_pxl, busy, done, err} !== 9'd0) begin
      n_fail++; $display("FAIL reset ctrl: got %b want 0", {rd_req, wr_req, wr_wom, we_pxl, we_mul, wr_pos_pxl, busy, done, err});
    end
    n_checks++;
    if (i !== 16'd0 || j !== 16'd0 || rd_addr !== 32'd0 || wr_addr !== 32'd0 || stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset data: i=%0d j=%0d rd=%h wr=%h st=%0d want 0", i, j, rd_addr, wr_addr, stall_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_frame;
    rd_dly = 0; wr_dly = 0;
    do_start(16'd8, 16'd3, 32'h100, 32'h400);
    run_frame(0, 0);
    check_stores("basic", 10, 32'h400);
    n_checks++;
    if (n_rd !== 20 || rd_log[0] !== 32'h100 || rd_log[1] !== 32'h108 || rd_log[2] !== 32'h101 || rd_log[11] !== 32'h110) begin
      n_fail++; $display("FAIL basic fetch: n=%0d a0=%h a1=%h a2=%h a11=%h want 20/100/108/101/110",
                         n_rd, rd_log[0], rd_log[1], rd_log[2], rd_log[11]);
    end
    n_checks++;
    if (stall_cnt !== 32'd0 || err !== 1'b0) begin
      n_fail++; $display("FAIL basic stall/err: st=%0d err=%b want 0/0", stall_cnt, err);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic post-done: done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_bad_dim;
    int bad;
    do_start(16'd3, 16'd5, 32'h100, 32'h400);
    @(negedge clk); start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0 || rd_req !== 1'b0) begin
      n_fail++; $display("FAIL bad_dim fin: done=%b err=%b busy=%b rd=%b want 1/1/0/0", done, err, busy, rd_req);
    end
    bad = 0;
    repeat (4) begin @(negedge clk); if (done !== 1'b0 || err !== 1'b1 || rd_req !== 1'b0 || wr_req !== 1'b0) bad++; end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL bad_dim hold: %0d bad cycles want 0", bad); end
    do_start(16'd4, 16'd1, 32'h100, 32'h400);
    @(negedge clk); start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || err !== 1'b1) begin
      n_fail++; $display("FAIL bad_dim h1: done=%b err=%b want 1/1", done, err);
    end
  endtask

  task automatic test_wrap;
    rd_dly = 0; wr_dly = 0;
    do_start(16'd4, 16'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    run_frame(0, 0);
    check_stores("wrap", 2, 32'hFFFF_FFFF);
    n_checks++;
    if (rd_log[0] !== 32'hFFFF_FFFE || rd_log[1] !== 32'h2 || rd_log[2] !== 32'h2 || rd_log[3] !== 32'h6 || st_log[1] !== 32'h0) begin
      n_fail++; $display("FAIL wrap addrs: %h %h %h %h st1=%h want fffffffe 2 2 6 0",
                         rd_log[0], rd_log[1], rd_log[2], rd_log[3], st_log[1]);
    end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL wrap err clear: got %b want 0", err); end
  endtask

  task automatic test_stall;
    rd_dly = 3; wr_dly = 0;
    do_start(16'd8, 16'd2, 32'h200, 32'h600);
    run_frame(0, 0);
    check_stores("stall", 5, 32'h600);
    n_checks++;
    if (stall_cnt !== 32'(EXP_STALL)) begin
      n_fail++; $display("FAIL stall count: got %0d want %0d", stall_cnt, EXP_STALL);
    end
    rd_dly = 0;
  endtask

  task automatic test_reset_in_store;
    rd_dly = 0; wr_dly = 100;
    do_start(16'd8, 16'd3, 32'h100, 32'h400);
    run_frame(0, 1);
    n_checks++;
    if (wr_req !== 1'b1 || wr_addr !== 32'h400) begin
      n_fail++; $display("FAIL rst_store pre: wr_req=%b addr=%h want 1/400", wr_req, wr_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wr_req !== 1'b0 || busy !== 1'b0 || rd_req !== 1'b0 || wr_addr !== 32'd0 || i !== 16'd0 || j !== 16'd0) begin
      n_fail++; $display("FAIL rst_store post: wr=%b busy=%b rd=%b wa=%h i=%0d j=%0d want 0", wr_req, busy, rd_req, wr_addr, i, j);
    end
    rst = 1'b0; rd_ack = 1'b1; wr_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0; wr_ack = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || rd_req !== 1'b0 || wr_req !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rst_store ack_after: busy=%b rd=%b wr=%b done=%b want 0", busy, rd_req, wr_req, done);
    end
    wr_dly = 0;
    do_start(16'd8, 16'd3, 32'h100, 32'h400);
    run_frame(0, 0);
    check_stores("restart", 10, 32'h400);
  endtask

  task automatic test_ignore;
    @(negedge clk); rd_ack = 1'b1; wr_ack = 1'b1;
    @(negedge clk); rd_ack = 1'b0; wr_ack = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || rd_req !== 1'b0 || wr_req !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL idle_ack: busy=%b rd=%b wr=%b done=%b want 0", busy, rd_req, wr_req, done);
    end
    rd_dly = 1; wr_dly = 1;
    do_start(16'd8, 16'd3, 32'h100, 32'h400);
    run_frame(5, 0);
    check_stores("mid_start", 10, 32'h400);
    n_checks++;
    if (n_rd !== 20 || rd_log[10] !== 32'h108 || rd_log[19] !== 32'h114) begin
      n_fail++; $display("FAIL mid_start fetch: n=%0d a10=%h a19=%h want 20/108/114", n_rd, rd_log[10], rd_log[19]);
    end
    rd_dly = 0; wr_dly = 0;
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_bad_dim;
    test_wrap;
    test_stall;
    test_reset_in_store;
    test_ignore;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
